// File: rtl/peripheral_bfm_tl_pkg.sv
// Shared types and constants for the peripheral TL bus functional models.
package peripheral_bfm_tl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] INCR   = 2'b01;

    // Worse of two responses; the encodings are ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/peripheral_bfm_master_tl_check.sv
// Protocol checker for the master BFM: flags ID mismatches and misplaced
// rlast. Only compiled when PERIPHERAL_BFM_MASTER_TL_CHECK_EN is defined.
`ifdef PERIPHERAL_BFM_MASTER_TL_CHECK_EN
module peripheral_bfm_master_tl_check (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       b_hs,
    input  logic       r_hs,
    input  logic [3:0] bid,
    input  logic [3:0] rid,
    input  logic       rlast,
    input  logic [3:0] id_q,
    input  logic [3:0] cnt_q,
    input  logic [3:0] len_q,
    output logic       err
);

    logic viol;

    // A violation is any handshake whose ID or last marker disagrees with the burst.
    always_comb begin
        viol = 1'b0;
        if (b_hs && (bid != id_q))
            viol = 1'b1;
        if (r_hs && ((rid != id_q) || (rlast != (cnt_q == len_q))))
            viol = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            err <= 1'b0;
        else if (viol)
            err <= 1'b1;
    end

endmodule
`endif

// File: rtl/peripheral_bfm_master_tl.sv
// AXI initiator BFM: one INCR burst (1-16 beats) per command, single
// outstanding transaction. Define PERIPHERAL_BFM_MASTER_TL_CHECK_EN to build
// in the protocol checker driving err; otherwise err is tied low.
module peripheral_bfm_master_tl
    import peripheral_bfm_tl_pkg::*;
#(
    parameter logic [2:0] AXSIZE  = 3'b010,
    parameter logic [3:0] AXCACHE = 4'b0000,
    parameter logic [2:0] AXPROT  = 3'b000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_id,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_strb,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_resp,
    output logic        rd_last,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic        err,
    output logic [3:0]  awid,
    output logic [31:0] awadr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wrdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    state_t      state, nxt;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [3:0]  id_q;
    logic [3:0]  cnt_q;
    logic [1:0]  worst_q;
    logic        accept, w_hs, r_hs, b_hs;

    assign accept = (state == IDLE)    && cmd_valid && aresetn;
    assign w_hs   = (state == WR_DATA) && wd_valid && wready;
    assign r_hs   = (state == RD_DATA) && rvalid && rd_ready;
    assign b_hs   = (state == WR_RESP) && bvalid;

    // State register; async reset aborts any burst in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Next state and all channel outputs; anything not driven by the current state stays 0.
    always_comb begin
        nxt       = state;
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_resp   = '0;
        rd_last   = 1'b0;
        done      = 1'b0;
        awid      = '0;
        awadr     = '0;
        awlen     = '0;
        awsize    = '0;
        awburst   = '0;
        awlock    = '0;
        awcache   = '0;
        awprot    = '0;
        awvalid   = 1'b0;
        wid       = '0;
        wrdata    = '0;
        wstrb     = '0;
        wlast     = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arlock    = '0;
        arcache   = '0;
        arprot    = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so the port reads 0 while reset is held.
                cmd_ready = aresetn;
                if (accept)
                    nxt = cmd_write ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                awid    = id_q;
                awadr   = addr_q;
                awlen   = len_q;
                awsize  = AXSIZE;
                awburst = INCR;
                awcache = AXCACHE;
                awprot  = AXPROT;
                if (awready)
                    nxt = WR_DATA;
            end
            WR_DATA: begin
                wvalid   = wd_valid;
                wrdata   = wd_data;
                wstrb    = wd_strb;
                wd_ready = wready;
                wid      = id_q;
                wlast    = (cnt_q == len_q);
                if (w_hs && (cnt_q == len_q))
                    nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid)
                    nxt = DONE;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                arid    = id_q;
                araddr  = addr_q;
                arlen   = len_q;
                arsize  = AXSIZE;
                arcache = AXCACHE;
                arprot  = AXPROT;
                if (arready)
                    nxt = RD_DATA;
            end
            RD_DATA: begin
                rd_valid = rvalid;
                rready   = rd_ready;
                rd_data  = rdata;
                rd_resp  = rresp;
                rd_last  = rlast;
                // Only rlast ends a read, even if it arrives late.
                if (r_hs && rlast)
                    nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Beat counter, worst read response and the reported completion response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q     <= '0;
            worst_q   <= OKAY;
            done_resp <= OKAY;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                worst_q <= OKAY;
            end else if (w_hs || r_hs) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (r_hs) begin
                worst_q <= resp_max(worst_q, rresp);
                if (rlast)
                    done_resp <= resp_max(worst_q, rresp);
            end
            if (b_hs)
                done_resp <= bresp;
        end
    end

    // Command fields captured at acceptance; outputs are state-gated so no reset is needed.
    always_ff @(posedge aclk) begin
        if (accept) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            id_q   <= cmd_id;
        end
    end

`ifdef PERIPHERAL_BFM_MASTER_TL_CHECK_EN
    peripheral_bfm_master_tl_check u_check (
        .aclk    (aclk),
        .aresetn (aresetn),
        .b_hs    (b_hs),
        .r_hs    (r_hs),
        .bid     (bid),
        .rid     (rid),
        .rlast   (rlast),
        .id_q    (id_q),
        .cnt_q   (cnt_q),
        .len_q   (len_q),
        .err     (err)
    );
`else
    logic unused_ids;
    assign unused_ids = ^{bid, rid};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_bfm_master_tl.sv
// Self-checking bench for peripheral_bfm_master_tl: randomised slave responder,
// transaction-level reference model and directed literal checks.
module tb_peripheral_bfm_master_tl;

    localparam logic [2:0] AXSIZE  = 3'b010;
    localparam logic [3:0] AXCACHE = 4'b0000;
    localparam logic [2:0] AXPROT  = 3'b000;

    logic aclk, aresetn;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0] cmd_len, cmd_id;
    logic wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0] wd_strb;
    logic rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic [1:0] rd_resp;
    logic rd_last, done, err;
    logic [1:0] done_resp;
    logic [3:0] awid, awlen, awcache;
    logic [31:0] awadr;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst, awlock;
    logic awvalid, awready;
    logic [3:0] wid, wstrb;
    logic [31:0] wrdata;
    logic wlast, wvalid, wready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic bvalid, bready;
    logic [3:0] arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0] arsize, arprot;
    logic [1:0] arlock;
    logic arvalid, arready;
    logic [3:0] rid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rlast, rvalid, rready;

    peripheral_bfm_master_tl #(.AXSIZE(AXSIZE), .AXCACHE(AXCACHE), .AXPROT(AXPROT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
        .rd_last(rd_last), .done(done), .done_resp(done_resp), .err(err),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rnd(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- slave responder knobs and burst contents ----------------
    int p_aw = 100, p_ar = 100, p_w = 100, p_b = 100, p_r = 100, p_wd = 100, p_rr = 100;
    bit w_alt = 0, bad_bid = 0;
    int aw_block = 0;
    logic [3:0] cur_id = '0, cur_len = '0;
    logic [1:0] cur_bresp = '0;
    logic [31:0] wdat [0:16];
    logic [3:0]  wstb [0:16];
    logic [31:0] rdat [0:16];
    logic [1:0]  rrsp [0:16];
    int s_w = 0, s_r = 0;

    // Slave side: samples handshakes at negedge, drives new inputs just after posedge.
    initial begin
        bit whs, rhs, acc, awv;
        awready = 0; arready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
        forever begin
            @(negedge aclk);
            whs = wd_valid && wd_ready;
            rhs = rvalid && rready;
            acc = cmd_valid && cmd_ready;
            awv = awvalid;
            @(posedge aclk);
            #2;
            if (!aresetn || acc) begin
                s_w = 0;
                s_r = 0;
            end else begin
                if (whs && s_w < 16) s_w++;
                if (rhs && s_r < 16) s_r++;
            end
            if (awv && aw_block > 0) aw_block--;
            awready  = (aw_block > 0) ? 1'b0 : rnd(p_aw);
            arready  = rnd(p_ar);
            wready   = w_alt ? ~wready : rnd(p_w);
            bvalid   = rnd(p_b);
            bid      = bad_bid ? 4'd5 : cur_id;
            bresp    = cur_bresp;
            rvalid   = rnd(p_r);
            rid      = cur_id;
            rdata    = rdat[s_r];
            rresp    = rrsp[s_r];
            rlast    = (s_r == int'(cur_len));
            wd_valid = rnd(p_wd);
            wd_data  = wdat[s_w];
            wd_strb  = wstb[s_w];
            rd_ready = rnd(p_rr);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction phases as seen from the bus, not the DUT encoding.
    typedef enum int {P_IDLE, P_AW, P_W, P_B, P_AR, P_R, P_END} phase_t;
    phase_t      mph = P_IDLE;
    logic [31:0] m_addr;
    logic [3:0]  m_len, m_id;
    int          m_beat;
    logic [1:0]  m_worst, m_dresp;
    logic        m_err;

    always @(negedge aclk) begin
        logic [54:0] e_aw;
        logic [42:0] e_w;
        logic [52:0] e_ar;
        logic [36:0] e_rd;
        logic [5:0]  e_ct;
        int bi;
        if (!aresetn) begin
            mph = P_IDLE; m_dresp = 2'b00; m_err = 1'b0; m_beat = 0; m_worst = 2'b00;
        end
        bi = (m_beat > 16) ? 16 : m_beat;
        e_aw = (mph == P_AW) ? {m_id, m_addr, m_len, AXSIZE, 2'b01, 2'b00, AXCACHE, AXPROT, 1'b1} : '0;
        e_w  = (mph == P_W) ? {m_id, wdat[bi], wd_strb, (m_beat == int'(m_len)), wd_valid, wready} : '0;
        e_ar = (mph == P_AR) ? {m_id, m_addr, m_len, AXSIZE, 2'b00, AXCACHE, AXPROT, 1'b1} : '0;
        e_rd = (mph == P_R) ? {rvalid, rdata, rresp, rlast, rd_ready} : '0;
        e_ct = {aresetn && (mph == P_IDLE), mph == P_END, mph == P_B, m_dresp, m_err};
        chk("aw_chan", {awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid}, e_aw);
        chk("w_chan", {wid, wrdata, wstrb, wlast, wvalid, wd_ready}, e_w);
        chk("ar_chan", {arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid}, e_ar);
        chk("rd_chan", {rd_valid, rd_data, rd_resp, rd_last, rready}, e_rd);
        chk("ctrl", {cmd_ready, done, bready, done_resp, err}, e_ct);
        if (aresetn) begin
            case (mph)
                P_IDLE: if (cmd_valid) begin
                    m_addr = cmd_addr; m_len = cmd_len; m_id = cmd_id;
                    m_beat = 0; m_worst = 2'b00;
                    mph = cmd_write ? P_AW : P_AR;
                end
                P_AW: if (awready) mph = P_W;
                P_W: if (wd_valid && wready) begin
                    if (m_beat == int'(m_len)) mph = P_B;
                    m_beat++;
                end
                P_B: if (bvalid) begin
`ifdef PERIPHERAL_BFM_MASTER_TL_CHECK_EN
                    if (bid != m_id) m_err = 1'b1;
`endif
                    m_dresp = bresp;
                    mph = P_END;
                end
                P_AR: if (arready) mph = P_R;
                P_R: if (rvalid && rd_ready) begin
`ifdef PERIPHERAL_BFM_MASTER_TL_CHECK_EN
                    if (rid != m_id || rlast != ((m_beat % 16) == int'(m_len))) m_err = 1'b1;
`endif
                    m_worst = worse(m_worst, rresp);
                    if (rlast) begin
                        m_dresp = m_worst;
                        mph = P_END;
                    end
                    m_beat++;
                end
                default: mph = P_IDLE;
            endcase
        end
    end

    // ---------------- transaction driver with observation ----------------
    int lat, n_whs, n_wlast, wlast_idx, n_rhs, n_awv;
    bit aw_bad, got_done, abort_vld, abort_done;
    logic [31:0] first_awadr;
    logic [3:0]  first_awid;
    logic [1:0]  resp_seen;
    logic [31:0] wq [$];

    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [3:0] l,
                           input logic [3:0] id, input int abort_at);
        int t;
        cur_id = id; cur_len = l;
        lat = 0; n_whs = 0; n_wlast = 0; wlast_idx = -1; n_rhs = 0; n_awv = 0;
        aw_bad = 0; got_done = 0; abort_vld = 0; abort_done = 0; wq.delete();
        first_awadr = '0; first_awid = '0; resp_seen = '0;
        @(posedge aclk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
        t = 0;
        @(negedge aclk);
        while (!cmd_ready && t < 100) begin
            t++;
            @(negedge aclk);
        end
        chk("cmd_accept_timeout", t < 100, 1'b1);
        @(posedge aclk); #1;
        cmd_valid = 0; cmd_addr = $urandom; cmd_len = 4'($urandom); cmd_id = 4'($urandom);
        for (int k = 1; k <= 2000; k++) begin
            @(negedge aclk);
            if (awvalid) begin
                if (n_awv == 0) begin first_awadr = awadr; first_awid = awid; end
                n_awv++;
                if (awadr != a || awid != id || cmd_ready) aw_bad = 1;
            end
            if (wvalid && wready) begin
                wq.push_back(wrdata);
                if (wlast) begin n_wlast++; wlast_idx = n_whs; end
                n_whs++;
            end
            if (rd_valid && rd_ready) n_rhs++;
            if (done) begin
                got_done = 1; lat = k; resp_seen = done_resp;
                break;
            end
            if (abort_at == k) begin
                @(posedge aclk); #1;
                aresetn = 0;
                #1;
                abort_vld = awvalid | wvalid | arvalid | rd_valid | bready | rready | wd_ready;
                abort_done = done;
                repeat (2) @(posedge aclk);
                #1 aresetn = 1;
                break;
            end
        end
        if (abort_at == 0) chk("done_timeout", got_done, 1'b1);
    endtask

    task automatic fill(input int err_beat);
        for (int i = 0; i <= 16; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'($urandom);
            rdat[i] = $urandom;
            rrsp[i] = (err_beat < 0) ? 2'($urandom) : ((i == err_beat) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic knobs(input int p);
        p_aw = p; p_ar = p; p_w = p; p_b = p; p_r = p; p_wd = p; p_rr = p;
    endtask

    initial begin
        logic [1:0] exp_resp;
        bit wr;
        logic [3:0] l;
        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        fill(-1);
        repeat (3) @(negedge aclk);
        chk("reset_outputs", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, done, done_resp, err}, 10'h0);
        @(posedge aclk); #1 aresetn = 1;

        // 1-beat write, all readies high: done four cycles after acceptance.
        knobs(100); cur_bresp = 2'b00; fill(-1);
        run_txn(1, 32'h1000, 4'd0, 4'd3, 0);
        chk("t1_latency", lat, 4);
        chk("t1_awadr", first_awadr, 32'h1000);
        chk("t1_awid", first_awid, 4'd3);
        chk("t1_wlast_cnt", n_wlast, 1);
        chk("t1_beats", n_whs, 1);
        chk("t1_resp", resp_seen, 2'b00);

        // 1-beat read latency is one cycle shorter.
        fill(-1); rrsp[0] = 2'b01;
        run_txn(0, 32'h2000, 4'd0, 4'd6, 0);
        chk("t1r_latency", lat, 3);
        chk("t1r_resp", resp_seen, 2'b01);

        // 4-beat write with wready alternating.
        fill(-1); w_alt = 1; cur_bresp = 2'b11;
        run_txn(1, 32'h3000, 4'd3, 4'd1, 0);
        w_alt = 0;
        chk("t2_beats", n_whs, 4);
        chk("t2_wlast_cnt", n_wlast, 1);
        chk("t2_wlast_idx", wlast_idx, 3);
        for (int i = 0; i < 4; i++) chk("t2_data_order", (wq.size() > i) ? wq[i] : 32'hx, wdat[i]);
        chk("t2_resp", resp_seen, 2'b11);

        // 16-beat read, SLVERR on beat 7, random rd_ready.
        fill(7); p_rr = 50; p_r = 70;
        run_txn(0, 32'h4000, 4'd15, 4'd9, 0);
        knobs(100);
        chk("t3_beats", n_rhs, 16);
        chk("t3_resp", resp_seen, 2'b10);

        // awready held low for 5 cycles: address stable, cmd_ready low.
        fill(-1); cur_bresp = 2'b00; aw_block = 5;
        run_txn(1, 32'h5000, 4'd1, 4'd2, 0);
        chk("t4_awvalid_cycles", n_awv, 6);
        chk("t4_aw_stable", aw_bad, 1'b0);

        // Wrong bid: err only with the checker built in, then sticky.
        fill(-1); bad_bid = 1;
        run_txn(1, 32'h6000, 4'd0, 4'd3, 0);
        bad_bid = 0;
        run_txn(1, 32'h6100, 4'd0, 4'd3, 0);
        @(negedge aclk);
`ifdef PERIPHERAL_BFM_MASTER_TL_CHECK_EN
        chk("t6_err_sticky", err, 1'b1);
`else
        chk("t6_err_tied", err, 1'b0);
`endif

        // Reset during the third write beat aborts with no done; next command completes.
        fill(-1);
        run_txn(1, 32'h7000, 4'd3, 4'd4, 3);
        chk("t5_abort_valids", abort_vld, 1'b0);
        chk("t5_abort_done", abort_done | got_done, 1'b0);
        chk("t5_err_cleared", err, 1'b0);
        fill(-1); cur_bresp = 2'b01;
        run_txn(1, 32'h7100, 4'd0, 4'd4, 0);
        chk("t5_recover_lat", lat, 4);
        chk("t5_recover_resp", resp_seen, 2'b01);

        // Randomised transactions.
        for (int n = 0; n < 40; n++) begin
            p_aw = $urandom_range(30, 100); p_ar = $urandom_range(30, 100);
            p_w = $urandom_range(30, 100);  p_b = $urandom_range(30, 100);
            p_r = $urandom_range(30, 100);  p_wd = $urandom_range(30, 100);
            p_rr = $urandom_range(30, 100);
            fill(-1);
            wr = 1'($urandom); l = 4'($urandom); cur_bresp = 2'($urandom);
            exp_resp = 2'b00;
            for (int i = 0; i <= int'(l); i++) exp_resp = worse(exp_resp, rrsp[i]);
            if (wr) exp_resp = cur_bresp;
            run_txn(wr, {$urandom} & 32'hFFFF_FFFC, l, 4'($urandom), 0);
            chk("rand_beats", wr ? n_whs : n_rhs, int'(l) + 1);
            chk("rand_resp", resp_seen, exp_resp);
            if (wr) chk("rand_wlast", wlast_idx, int'(l));
        end

        repeat (3) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/peripheral_bfm_master_tl.md
# peripheral_bfm_master_tl

AXI initiator bus functional model for MPSoC DMA testbenches; the counterpart of `peripheral_bfm_slave_tl`, driving the same channel signal set from the master side. A simple command port triggers one INCR write or read burst of 1-16 beats. Write data is streamed in through a beat port, read data is streamed out, and a completion pulse reports the response. Only one transaction is outstanding at a time.

## Interface
- `AXSIZE`, default 3'b010: value driven on `awsize`/`arsize` (4-byte beats).
- `AXCACHE`, default 4'b0000: value driven on `awcache`/`arcache`.
- `AXPROT`, default 3'b000: value driven on `awprot`/`arprot`.
- `aclk`  in  1  the single clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`/`cmd_ready`  in/out  1  command handshake.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  32  start address.
- `cmd_len`  in  4  beats minus 1.
- `cmd_id`  in  4  transaction ID.
- `wd_valid`/`wd_ready`  in/out  1  write-beat handshake.
- `wd_data`  in  32  write-beat data.
- `wd_strb`  in  4  write-beat byte strobes.
- `rd_valid`/`rd_ready`  out/in  1  read-beat handshake.
- `rd_data`  out  32  read-beat data.
- `rd_resp`  out  2  read-beat response.
- `rd_last`  out  1  marks the final read beat.
- `done`  out  1  one-cycle completion pulse.
- `done_resp`  out  2  `bresp`, or the worst `rresp` of the burst.
- `err`  out  1  sticky checker flag (see Configuration).
- Write address channel, all out except `awready` (in): `awid` 4, `awadr` 32, `awlen` 4, `awsize` 3, `awburst` 2, `awlock` 2, `awcache` 4, `awprot` 3, `awvalid` 1, `awready` 1.
- Write data channel, all out except `wready` (in): `wid` 4, `wrdata` 32, `wstrb` 4, `wlast` 1, `wvalid` 1, `wready` 1.
- Write response channel: `bid` 4 in, `bresp` 2 in, `bvalid` 1 in, `bready` 1 out.
- Read address channel, all out except `arready` (in): `arid` 4, `araddr` 32, `arlen` 4, `arsize` 3, `arlock` 2, `arcache` 4, `arprot` 3, `arvalid` 1, `arready` 1.
- Read data channel: `rid` 4 in, `rdata` 32 in, `rresp` 2 in, `rlast` 1 in, `rvalid` 1 in, `rready` 1 out.

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch addr/len/id/write into registers and clear the beat counter and worst-response register.
  - Go to WR_ADDR or RD_ADDR.
- WR_ADDR / RD_ADDR:
  - `awvalid`/`arvalid` = 1.
  - Address fields come from the latched registers; `awburst` = INCR; lock = 0.
  - Leave the state on the cycle `awready`/`arready` is sampled 1.
- WR_DATA:
  - `wvalid` = `wd_valid`, `wrdata` = `wd_data`, `wstrb` = `wd_strb`, `wd_ready` = `wready`, `wid` = latched id.
  - `wlast` = (beat counter == latched len).
  - The counter increments on each `wvalid`&`wready`.
  - The beat with `wlast` set moves the FSM to WR_RESP.
- WR_RESP:
  - `bready` = 1.
  - On `bvalid`, capture `bresp` into `done_resp` and go to DONE.
- RD_DATA:
  - `rd_valid` = `rvalid`, `rready` = `rd_ready`; `rd_data`/`rd_resp`/`rd_last` pass `rdata`/`rresp`/`rlast` through.
  - Each handshake updates worst response = max(worst, `rresp`) as an unsigned compare.
  - The handshake with `rlast` = 1 captures the worst response into `done_resp` and goes to DONE.
- DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- Address is never incremented by the master; `awadr`/`araddr` always carry the start address.
- All channel outputs not named in the current state are 0.

## Timing
- Reset:
  - All outputs are 0: valids, readies, `done`, `err`, `done_resp`, and all address/data/ID fields.
  - FSM goes to IDLE.
  - Reset asserted mid-burst aborts immediately with no `done`; no residual valid survives.
- Address valid is registered and rises the cycle after command acceptance.
- It is held stable with constant fields until `awready`/`arready` is sampled 1. This holds even if `awready` was already 1 before `awvalid` rose.
- Minimum write latency: command to `done` = 4 cycles for a 1-beat write with all readies high (WR_ADDR, WR_DATA, WR_RESP, DONE).
- Minimum read latency: same as write, minus WR_RESP.
- `cmd_ready` is 0 from acceptance through DONE. The back-to-back command rate is one per transaction plus the IDLE cycle.
- `bvalid` or `rvalid` arriving before the corresponding state is ignored; `bready`/`rready` stay 0 until then.
- A 16-beat burst (len = 15) with `wready` toggling completes with exactly 16 handshakes. The counter is 4 bits and does not wrap within a burst.

## Configuration
- `PERIPHERAL_BFM_MASTER_TL_CHECK_EN` defined: the protocol checker is instantiated. `err` is set sticky, cleared only by reset, when any of the following occurs:
  - `bid` ≠ latched id on the B handshake.
  - `rid` ≠ latched id on any R handshake.
  - `rlast` arrives before beat len, or is missing at beat len. A missing `rlast` does not end the burst; the FSM still waits for `rlast`.
- Not defined: no checker; `err` is tied 0.

## Structure
- Package `peripheral_bfm_tl_pkg` holds:
  - the FSM state enum;
  - response constants OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11;
  - burst constant INCR 2'b01.
- Sub-module `peripheral_bfm_master_tl_check` contains the checker. It compiles only under the macro.

## Test plan
- Write, addr 0x1000, len 0, id 3, all readies 1, `bresp` OKAY → `awadr` = 0x1000, `awid` = 3, one beat with `wlast` = 1, `done` 4 cycles after acceptance, `done_resp` = 2'b00.
- Write, len 3, `wready` alternating 0/1 → exactly 4 handshakes; `wlast` only on the 4th beat; data order preserved.
- Read, len 15, `rresp` OKAY except beat 7 = SLVERR, `rd_ready` random → 16 `rd_valid` beats forwarded, `done_resp` = 2'b10.
- `awready` held 0 for 5 cycles → `awvalid` and `awadr` stay stable for all 5 cycles; `cmd_ready` stays 0.
- Reset asserted during WR_DATA beat 2 → all valids 0 on the same edge, no `done`; the next command completes normally.
- With the macro: `bid` = 5 for a transaction with id 3 → `err` = 1 and stays 1; without the macro, `err` = 0.
